// File: rtl/data_path.sv
// data_path: single-bus 32-bit CPU datapath slice.
// Shared bus with fixed-priority source select, PC/IR/MAR/MDR/Y, 64-bit Z,
// general registers R1-R3 and a small ALU (increment, AND, pass-through).
// Optional build macro DATAPATH_BUS_CHECK_EN adds the BusConflict output
// and a simulation warning when more than one bus source is selected.
module data_path (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        PCout,
  input  logic        Zlowout,
  input  logic        MDRout,
  input  logic        R2out,
  input  logic        R3out,
  input  logic        MARin,
  input  logic        Zin,
  input  logic        PCin,
  input  logic        MDRin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        R1in,
  input  logic        R2in,
  input  logic        R3in,
  input  logic        IncPC,
  input  logic        Read,
  input  logic        AND,
  input  logic [31:0] Mdatain,
`ifdef DATAPATH_BUS_CHECK_EN
  output logic        BusConflict,
`endif
  output logic [31:0] BusMuxOut,
  output logic [31:0] PC_q,
  output logic [31:0] IR_q,
  output logic [31:0] MAR_q,
  output logic [31:0] R1_q
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] mar_q, mar_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] y_q, y_d;
  logic [63:0] z_q, z_d;
  logic [31:0] r1_q, r1_d;
  logic [31:0] r2_q, r2_d;
  logic [31:0] r3_q, r3_d;
  logic [31:0] bus;
  logic [63:0] alu_result;

  // Bus source mux; Zlowout has highest priority, no select drives zero.
  always_comb begin
    bus = 32'h0;
    if (Zlowout) begin
      bus = z_q[31:0];
    end else if (MDRout) begin
      bus = mdr_q;
    end else if (PCout) begin
      bus = pc_q;
    end else if (R2out) begin
      bus = r2_q;
    end else if (R3out) begin
      bus = r3_q;
    end
  end

  // ALU: IncPC beats AND; otherwise the bus passes through. Upper half is zero.
  always_comb begin
    alu_result = {32'h0, bus};
    if (IncPC) begin
      alu_result = {32'h0, bus + 32'd1};
    end else if (AND) begin
      alu_result = {32'h0, y_q & bus};
    end
  end

  // Next-state: strobed registers take the bus, all others hold.
  always_comb begin
    pc_d  = PCin  ? bus : pc_q;
    ir_d  = IRin  ? bus : ir_q;
    mar_d = MARin ? bus : mar_q;
    y_d   = Yin   ? bus : y_q;
    r1_d  = R1in  ? bus : r1_q;
    r2_d  = R2in  ? bus : r2_q;
    r3_d  = R3in  ? bus : r3_q;
    z_d   = Zin   ? alu_result : z_q;
    mdr_d = mdr_q;
    if (MDRin) begin
      mdr_d = Read ? Mdatain : bus;
    end
  end

  // State registers; async reset clears everything and masks loads.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pc_q  <= 32'h0;
      ir_q  <= 32'h0;
      mar_q <= 32'h0;
      mdr_q <= 32'h0;
      y_q   <= 32'h0;
      z_q   <= 64'h0;
      r1_q  <= 32'h0;
      r2_q  <= 32'h0;
      r3_q  <= 32'h0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      y_q   <= y_d;
      z_q   <= z_d;
      r1_q  <= r1_d;
      r2_q  <= r2_d;
      r3_q  <= r3_d;
    end
  end

  assign BusMuxOut = bus;
  assign PC_q      = pc_q;
  assign IR_q      = ir_q;
  assign MAR_q     = mar_q;
  assign R1_q      = r1_q;

`ifdef DATAPATH_BUS_CHECK_EN
  logic [2:0] sel_cnt;

  // Count active bus sources; more than one is a conflict.
  always_comb begin
    sel_cnt = 3'(PCout) + 3'(Zlowout) + 3'(MDRout) + 3'(R2out) + 3'(R3out);
  end

  assign BusConflict = (sel_cnt > 3'd1);

`ifndef SYNTHESIS
  // Warn on every edge where several sources fight for the bus.
  always @(posedge Clock) begin
    if (BusConflict) begin
      $display("[data_path] warning: %0d bus sources selected at %0t", sel_cnt, $time);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_data_path.sv
// tb_data_path: directed + randomized bench for data_path with a
// register-transfer reference model kept in the bench.
module tb_data_path;

  // Strobe bit positions in the bench's control word.
  localparam int SPcOut = 0,  SZlo  = 1,  SMdrOut = 2,  SR2Out = 3,  SR3Out = 4;
  localparam int SMarIn = 5,  SZIn  = 6,  SPcIn   = 7,  SMdrIn = 8,  SIrIn  = 9;
  localparam int SYIn   = 10, SR1In = 11, SR2In   = 12, SR3In  = 13, SInc   = 14;
  localparam int SRead  = 15, SAnd  = 16;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b1;
  logic        PCout, Zlowout, MDRout, R2out, R3out;
  logic        MARin, Zin, PCin, MDRin, IRin, Yin, R1in, R2in, R3in;
  logic        IncPC, Read, AND;
  logic [31:0] Mdatain;
  logic [31:0] BusMuxOut, PC_q, IR_q, MAR_q, R1_q;
`ifdef DATAPATH_BUS_CHECK_EN
  logic        BusConflict;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_r1, m_r2, m_r3;
  logic [63:0] m_z;
  logic [16:0] cur_s;
  logic [31:0] cur_md;

  data_path u_dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .PCout     (PCout),
    .Zlowout   (Zlowout),
    .MDRout    (MDRout),
    .R2out     (R2out),
    .R3out     (R3out),
    .MARin     (MARin),
    .Zin       (Zin),
    .PCin      (PCin),
    .MDRin     (MDRin),
    .IRin      (IRin),
    .Yin       (Yin),
    .R1in      (R1in),
    .R2in      (R2in),
    .R3in      (R3in),
    .IncPC     (IncPC),
    .Read      (Read),
    .AND       (AND),
    .Mdatain   (Mdatain),
`ifdef DATAPATH_BUS_CHECK_EN
    .BusConflict(BusConflict),
`endif
    .BusMuxOut (BusMuxOut),
    .PC_q      (PC_q),
    .IR_q      (IR_q),
    .MAR_q     (MAR_q),
    .R1_q      (R1_q)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_bus(input logic [16:0] s);
    if (s[SZlo])         return m_z[31:0];
    else if (s[SMdrOut]) return m_mdr;
    else if (s[SPcOut])  return m_pc;
    else if (s[SR2Out])  return m_r2;
    else if (s[SR3Out])  return m_r3;
    return 32'h0;
  endfunction

  task automatic m_reset();
    m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_y = 0;
    m_r1 = 0; m_r2 = 0; m_r3 = 0; m_z = 0;
  endtask

  // Apply strobes just after the falling edge and check the bus.
  task automatic drive(input logic [16:0] s, input logic [31:0] md);
    @(negedge Clock);
    cur_s = s; cur_md = md;
    PCout = s[SPcOut]; Zlowout = s[SZlo]; MDRout = s[SMdrOut];
    R2out = s[SR2Out]; R3out = s[SR3Out];
    MARin = s[SMarIn]; Zin = s[SZIn]; PCin = s[SPcIn]; MDRin = s[SMdrIn];
    IRin = s[SIrIn]; Yin = s[SYIn]; R1in = s[SR1In]; R2in = s[SR2In]; R3in = s[SR3In];
    IncPC = s[SInc]; Read = s[SRead]; AND = s[SAnd];
    Mdatain = md;
    #1;
    check("bus", {32'h0, BusMuxOut}, {32'h0, m_bus(s)});
  endtask

  // Rising edge: advance the model with the pre-edge bus, then compare.
  task automatic tick();
    logic [31:0] b;
    logic [31:0] alu;
    @(posedge Clock);
    if (!Resetn) begin
      m_reset();
    end else begin
      b = m_bus(cur_s);
      if (cur_s[SInc])      alu = b + 1;
      else if (cur_s[SAnd]) alu = m_y & b;
      else                  alu = b;
      if (cur_s[SZIn])   m_z = {32'h0, alu};
      if (cur_s[SMdrIn]) m_mdr = cur_s[SRead] ? cur_md : b;
      if (cur_s[SMarIn]) m_mar = b;
      if (cur_s[SPcIn])  m_pc = b;
      if (cur_s[SIrIn])  m_ir = b;
      if (cur_s[SYIn])   m_y = b;
      if (cur_s[SR1In])  m_r1 = b;
      if (cur_s[SR2In])  m_r2 = b;
      if (cur_s[SR3In])  m_r3 = b;
    end
    #1;
    check("pc",  {32'h0, PC_q},  {32'h0, m_pc});
    check("ir",  {32'h0, IR_q},  {32'h0, m_ir});
    check("mar", {32'h0, MAR_q}, {32'h0, m_mar});
    check("r1",  {32'h0, R1_q},  {32'h0, m_r1});
  endtask

  task automatic step(input logic [16:0] s, input logic [31:0] md);
    drive(s, md);
    tick();
  endtask

  function automatic logic [16:0] sb(input int a, input int b = -1, input int c = -1,
                                     input int d = -1);
    logic [16:0] v;
    v = '0;
    v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    if (d >= 0) v[d] = 1'b1;
    return v;
  endfunction

  // Load a constant into MDR from memory.
  task automatic load_mdr(input logic [31:0] v);
    step(sb(SRead, SMdrIn), v);
  endtask

  initial begin
    logic [16:0] rs;
    m_reset();
    cur_s = '0; cur_md = '0;
    drive('0, 32'h0);
    Resetn = 1'b0;
    #2;
    Resetn = 1'b1;
    #1;
    check("reset_pc", {32'h0, PC_q}, 64'h0);
    check("reset_r1", {32'h0, R1_q}, 64'h0);
    tick();

    // Reset mid-cycle clears immediately.
    load_mdr(32'h5);
    step(sb(SMdrOut, SR1In), 32'h0);
    check("r1_loaded", {32'h0, R1_q}, 64'h5);
    #2;
    Resetn = 1'b0;
    #1;
    m_reset();
    check("async_r1",  {32'h0, R1_q},  64'h0);
    check("async_pc",  {32'h0, PC_q},  64'h0);
    check("async_ir",  {32'h0, IR_q},  64'h0);
    check("async_mar", {32'h0, MAR_q}, 64'h0);
    // Loads ignored while reset held across an edge.
    step(sb(SRead, SMdrIn, SR1In, SPcIn), 32'hDEAD_BEEF);
    @(negedge Clock);
    Resetn = 1'b1;
    drive(sb(SZlo), 32'h0);
    check("z_after_reset", {32'h0, BusMuxOut}, 64'h0);
    tick();

    // Registers loaded via MDR.
    load_mdr(32'h12); step(sb(SMdrOut, SR2In), 0);
    load_mdr(32'h14); step(sb(SMdrOut, SR3In), 0);
    load_mdr(32'h18); step(sb(SMdrOut, SR1In), 0);
    check("r1_0x18", {32'h0, R1_q}, 64'h18);
    drive(sb(SR2Out), 0);
    check("r2_0x12", {32'h0, BusMuxOut}, 64'h12);
    tick();

    // Canonical AND instruction, PC = 0.
    step(sb(SPcOut, SMarIn, SInc, SZIn), 0);
    check("t0_mar", {32'h0, MAR_q}, 64'h0);
    step(sb(SZlo, SPcIn, SRead, SMdrIn), 32'h2891_8000);
    check("t1_pc", {32'h0, PC_q}, 64'h1);
    step(sb(SMdrOut, SIrIn), 0);
    check("t2_ir", {32'h0, IR_q}, 64'h2891_8000);
    step(sb(SR2Out, SYIn), 0);
    step(sb(SR3Out, SAnd, SZIn), 0);
    drive(sb(SZlo, SR1In), 0);
    check("t5_zlo", {32'h0, BusMuxOut}, 64'h10);
    tick();
    check("t5_r1", {32'h0, R1_q}, 64'h10);

    // Bus priority.
    load_mdr(32'hC); step(sb(SMdrOut, SPcIn), 0);
    load_mdr(32'hA); step(sb(SMdrOut, SZIn), 0);
    load_mdr(32'hB);
    drive(sb(SZlo, SMdrOut, SPcOut), 0);
    check("prio_z", {32'h0, BusMuxOut}, 64'hA);
    tick();
    drive(sb(SMdrOut, SPcOut), 0);
    check("prio_mdr", {32'h0, BusMuxOut}, 64'hB);
    tick();
    drive('0, 0);
    check("prio_none", {32'h0, BusMuxOut}, 64'h0);
`ifdef DATAPATH_BUS_CHECK_EN
    check("conflict_none", {63'h0, BusConflict}, 64'h0);
`endif
    tick();
`ifdef DATAPATH_BUS_CHECK_EN
    drive(sb(SPcOut, SR2Out), 0);
    check("conflict_two", {63'h0, BusConflict}, 64'h1);
    tick();
    drive(sb(SR2Out), 0);
    check("conflict_one", {63'h0, BusConflict}, 64'h0);
    tick();
`endif

    // IncPC wrap.
    load_mdr(32'hFFFF_FFFF); step(sb(SMdrOut, SPcIn), 0);
    step(sb(SPcOut, SMarIn, SInc, SZIn), 0);
    step(sb(SZlo, SPcIn), 0);
    check("pc_wrap", {32'h0, PC_q}, 64'h0);

    // IncPC beats AND.
    load_mdr(32'h0F); step(sb(SMdrOut, SYIn), 0);
    load_mdr(32'h3);  step(sb(SMdrOut, SInc, SAnd, SZIn), 0);
    drive(sb(SZlo), 0);
    check("inc_over_and", {32'h0, BusMuxOut}, 64'h4);
    tick();

    // Randomized strobes with occasional asynchronous reset pulses.
    for (int i = 0; i < 400; i++) begin
      rs = 17'($urandom);
      step(rs, $urandom);
      if ($urandom_range(0, 49) == 0) begin
        #1;
        Resetn = 1'b0;
        #1;
        m_reset();
        check("rand_async_pc", {32'h0, PC_q}, 64'h0);
        Resetn = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
